if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the five-stage RV32I pipeline.
- Owns the PC and drives the word address of the combinational instruction ROM.
- Registers the fetched instruction and its PC for decode. Decode forwards id_imm_din/id_pc to the immediate extender.
- Stall comes from the hazard unit; redirect (taken branch, jal, jalr) comes from EX.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INST, 32'h0000_0013: bubble instruction (addi x0,x0,0).
- IROM_AW, 14: instruction ROM word-address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents (load-use hazard)
- redirect  input  1  EX resolved a control transfer; flush and jump
- redirect_pc  input  32  target PC from EX (branch/jal/jalr pc_imm path)
- irom_addr  output  IROM_AW  ROM word address = pc_q[IROM_AW+1:2]
- irom_inst  input  32  ROM data, combinational from irom_addr
- if_pc  output  32  current fetch PC (pc_q)
- id_valid  output  1  IF/ID holds a real instruction
- id_pc  output  32  PC of instruction in IF/ID
- id_pc4  output  32  id_pc + 4 (jal/jalr link value)
- id_inst  output  32  instruction in IF/ID
- id_imm_din  output  25  id_inst[31:7], feeds immediate extender din

Behaviour:
- Reset (rst=1 at edge): pc_q <= RESET_PC; id_valid <= 0; id_inst <= NOP_INST; id_pc <= 0. rst dominates stall and redirect. Outputs hold these values until the first non-reset edge.
- PC next-state, in priority order:
  - rst
  - redirect: pc_q <= {redirect_pc[31:2],2'b00}; low two bits are dropped, with no exception.
  - stall: pc_q holds.
  - otherwise: pc_q <= pc_q + 4.
- PC arithmetic is 32-bit modulo. 0xFFFF_FFFC + 4 wraps to 0x0000_0000 silently.
- IF/ID next-state, in priority order:
  - rst
  - redirect: flush; id_valid <= 0, id_inst <= NOP_INST, id_pc <= pc_q. Applies even if stall=1.
  - stall: all IF/ID fields hold.
  - otherwise: id_inst <= irom_inst, id_pc <= pc_q, id_valid <= 1.
- Latency: instruction at pc_q in cycle n appears on id_* in cycle n+1.
- Redirect penalty: a redirect asserted in cycle n fetches redirect_pc in cycle n+1. Its instruction reaches id_* in cycle n+2, and id_valid=0 in cycle n+1 (one bubble from this stage; EX flushes ID itself).
- Simultaneous stall+redirect: redirect wins for both PC and IF/ID.
- Stall held for k cycles: id_* and pc_q are bit-identical for all k cycles. Fetch resumes with pc_q+4 on the first cycle after stall drops.
- Reset mid-stream: pending stall/redirect are discarded; the first post-reset fetch is RESET_PC.
- id_pc4, id_imm_din, irom_addr and if_pc are purely combinational from registers. No combinational path exists from stall/redirect to any output.
- No X-propagation: id_inst is never taken from irom_inst while rst=1.

Decomposition:
- Shared defines header: NOP_INST, RESET_PC, IROM_AW. Place them alongside the existing SEXT_* op defines.
- One natural sub-module, pc_reg: clk, rst, stall, redirect, redirect_pc, outputs pc_q. It contains the next-PC mux and the +4 adder.
- The IF/ID register lives in if_id_stage.

Test Plan:
- Reset then free-run with ROM word i = 0x00100093+i: cycles 1..4 give id_pc 0,4,8,12 and id_inst words 0..3, with id_valid=0 in the first cycle after reset.
- Stall 3 cycles while id_pc=0x8: id_pc/id_inst held, if_pc=0xC held. Release gives id_pc=0xC next cycle.
- Redirect to 0x40 while id_pc=0x4: next cycle id_valid=0, id_inst=0x00000013, if_pc=0x40. Cycle after, id_pc=0x40, id_pc4=0x44, id_valid=1.
- stall=1 and redirect=1 with redirect_pc=0x103: if_pc=0x100, IF/ID flushed to NOP. Misaligned low bits dropped.
- Force pc_q=0xFFFFFFFC via redirect, run one cycle: if_pc=0x00000000, id_pc=0xFFFFFFFC.
- rst asserted during a stall with redirect active: next edge gives if_pc=RESET_PC, id_valid=0, id_inst=NOP_INST. id_imm_din equals id_inst[31:7] throughout.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared constants and types for the fetch stage and IF/ID pipeline register.
package if_id_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
    localparam int          IROM_AW  = 14;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    // Redirect targets are forced to word alignment; low bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter with next-PC priority mux (reset, redirect, stall, +4).
module if_id_stage_pc_reg
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_q
);

    logic [31:0] r_pc;
    logic        w_unused_lsbs;

    assign w_unused_lsbs = ^redirect_pc[1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC_P;
        end else if (redirect) begin
            r_pc <= align_word(redirect_pc);
        end else if (!stall) begin
            r_pc <= r_pc + 32'd4;  // modulo 2^32, wraps silently
        end
    end

    assign pc_q = r_pc;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID register: drives the ROM address from the PC and
// latches the fetched word and its PC for decode; redirect flushes, stall holds.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC,
    parameter logic [31:0] NOP_INST_P = NOP_INST,
    parameter int          IROM_AW_P  = IROM_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [IROM_AW_P-1:0] irom_addr,
    input  logic [31:0]          irom_inst,
    output logic [31:0]          if_pc,
    output logic                 id_valid,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc4,
    output logic [31:0]          id_inst,
    output logic [24:0]          id_imm_din
);

    logic [31:0] w_pc_q;
    if_id_t      r_id;

    if_id_stage_pc_reg #(
        .RESET_PC_P (RESET_PC_P)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_q        (w_pc_q)
    );

    // Reset is checked first so irom_inst can never reach the register while rst=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id.valid <= 1'b0;
            r_id.pc    <= 32'd0;
            r_id.inst  <= NOP_INST_P;
        end else if (redirect) begin
            r_id.valid <= 1'b0;
            r_id.pc    <= w_pc_q;
            r_id.inst  <= NOP_INST_P;
        end else if (!stall) begin
            r_id.valid <= 1'b1;
            r_id.pc    <= w_pc_q;
            r_id.inst  <= irom_inst;
        end
    end

    assign irom_addr  = w_pc_q[IROM_AW_P+1:2];
    assign if_pc      = w_pc_q;
    assign id_valid   = r_id.valid;
    assign id_pc      = r_id.pc;
    assign id_pc4     = r_id.pc + 32'd4;
    assign id_inst    = r_id.inst;
    assign id_imm_din = r_id.inst[31:7];

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed steps push hand-computed post-edge
// state; a monitor pops and compares one entry after every rising edge.
module tb_if_id_stage;

    typedef struct {
        logic [31:0] if_pc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [13:0] irom_addr;
    logic [31:0] irom_inst;
    logic [31:0] if_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic [24:0] id_imm_din;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    // ROM word i holds 0x00100093 + i
    assign irom_inst = 32'h0010_0093 + {18'd0, irom_addr};

    if_id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irom_addr   (irom_addr),
        .irom_inst   (irom_inst),
        .if_pc       (if_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_inst     (id_inst),
        .id_imm_din  (id_imm_din)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] e_imm;
            logic [31:0] e_pc4;
            logic [31:0] e_addr;
            e      = exp_q.pop_front();
            e_imm  = {7'd0, e.inst[31:7]};
            e_pc4  = e.pc + 32'd4;
            e_addr = {18'd0, e.if_pc[15:2]};
            check("if_pc",      if_pc, e.if_pc);
            check("id_valid",   {31'd0, id_valid}, {31'd0, e.valid});
            check("id_pc",      id_pc, e.pc);
            check("id_inst",    id_inst, e.inst);
            check("id_pc4",     id_pc4, e_pc4);
            check("id_imm_din", {7'd0, id_imm_din}, e_imm);
            check("irom_addr",  {18'd0, irom_addr}, e_addr);
        end
    end

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                        input logic [31:0] e_ifpc, input logic e_v,
                        input logic [31:0] e_pc, input logic [31:0] e_inst);
        exp_t e;
        @(negedge clk);
        rst         = r;
        stall       = s;
        redirect    = d;
        redirect_pc = rpc;
        e.if_pc = e_ifpc;
        e.valid = e_v;
        e.pc    = e_pc;
        e.inst  = e_inst;
        exp_q.push_back(e);
    endtask

    initial begin
        //    rst  stl  red  redirect_pc     if_pc          v     id_pc          id_inst
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         NOP);
        step(1'b1, 1'b1, 1'b1, 32'h80,        32'h0,         1'b0, 32'h0,         NOP);
        // free run
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         1'b1, 32'h0,         32'h0010_0093);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         1'b1, 32'h4,         32'h0010_0094);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'h0010_0095);
        // stall 3 cycles with id_pc=0x8
        step(1'b0, 1'b1, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'h0010_0095);
        step(1'b0, 1'b1, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'h0010_0095);
        step(1'b0, 1'b1, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'h0010_0095);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h10,        1'b1, 32'hC,         32'h0010_0096);
        // redirect to 0x40
        step(1'b0, 1'b0, 1'b1, 32'h40,        32'h40,        1'b0, 32'h10,        NOP);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h44,        1'b1, 32'h40,        32'h0010_00A3);
        // stall + redirect to misaligned 0x103
        step(1'b0, 1'b1, 1'b1, 32'h103,       32'h100,       1'b0, 32'h44,        NOP);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h104,       1'b1, 32'h100,       32'h0010_00D3);
        // PC wrap
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 32'h104,       NOP);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0010_4092);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         1'b1, 32'h0,         32'h0010_0093);
        // reset during stall with redirect active
        step(1'b1, 1'b1, 1'b1, 32'h200,       32'h0,         1'b0, 32'h0,         NOP);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         1'b1, 32'h0,         32'h0010_0093);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         1'b1, 32'h4,         32'h0010_0094);
        // redirect to 0x40 while id_pc=0x4
        step(1'b0, 1'b0, 1'b1, 32'h40,        32'h40,        1'b0, 32'h8,         NOP);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h44,        1'b1, 32'h40,        32'h0010_00A3);
        step(1'b0, 1'b1, 1'b0, 32'h0,         32'h44,        1'b1, 32'h40,        32'h0010_00A3);
        @(negedge clk);
        stall = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
